// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU constants: exception codes, address map, NOP
package cpu_defs;

    localparam logic [4:0]  EXC_NONE   = 5'd0;
    localparam logic [4:0]  EXC_ADEL   = 5'd4;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
    localparam logic [31:0] IM_BASE    = 32'h0000_3000;
    localparam logic [31:0] IM_LAST    = 32'h0000_6FFC;

    localparam logic [31:0] NOP        = 32'h0000_0000;

endpackage

// File: rtl/ifu_fetch_stage_if.sv
// rtl/ifu_fetch_stage_if.sv - fetch stage control, IM bus and F/D outputs
interface ifu_fetch_stage_if;

    logic        stall;
    logic        req;
    logic        jump_flag;
    logic [31:0] jump_target;
    logic        d_is_jump;
    logic        d_is_eret;
    logic [31:0] i_inst_addr;
    logic [31:0] i_inst_rdata;
    logic [31:0] F_pc;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic [4:0]  D_exc;
    logic        D_bd;

    // Fetch stage side
    modport master (
        input  stall, req, jump_flag, jump_target, d_is_jump, d_is_eret, i_inst_rdata,
        output i_inst_addr, F_pc, D_instr, D_pc, D_exc, D_bd
    );

    // Surrounding pipeline / memory side
    modport slave (
        output stall, req, jump_flag, jump_target, d_is_jump, d_is_eret, i_inst_rdata,
        input  i_inst_addr, F_pc, D_instr, D_pc, D_exc, D_bd
    );

endinterface

// File: rtl/fd_pipe_reg.sv
// rtl/fd_pipe_reg.sv - F/D pipeline register with flush > stall > kill priority
module fd_pipe_reg #(
    parameter logic [31:0] RESET_PC   = cpu_defs::RESET_PC,
    parameter logic [31:0] HANDLER_PC = cpu_defs::HANDLER_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        stall,
    input  logic        kill,
    input  logic [31:0] f_instr,
    input  logic [31:0] f_pc,
    input  logic [4:0]  f_exc,
    input  logic        f_bd,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic [4:0]  d_exc,
    output logic        d_bd
);

    // Flush and kill still load a PC so EPC taken from D stays meaningful
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_instr <= cpu_defs::NOP;
            d_pc    <= RESET_PC;
            d_exc   <= cpu_defs::EXC_NONE;
            d_bd    <= 1'b0;
        end else if (flush) begin
            d_instr <= cpu_defs::NOP;
            d_pc    <= HANDLER_PC;
            d_exc   <= cpu_defs::EXC_NONE;
            d_bd    <= 1'b0;
        end else if (stall) begin
            d_instr <= d_instr;
            d_pc    <= d_pc;
            d_exc   <= d_exc;
            d_bd    <= d_bd;
        end else if (kill) begin
            d_instr <= cpu_defs::NOP;
            d_pc    <= f_pc;
            d_exc   <= cpu_defs::EXC_NONE;
            d_bd    <= 1'b0;
        end else begin
            d_instr <= f_instr;
            d_pc    <= f_pc;
            d_exc   <= f_exc;
            d_bd    <= f_bd;
        end
    end

endmodule

// File: rtl/ifu_fetch_stage.sv
// rtl/ifu_fetch_stage.sv - PC register, fetch address check and F/D register
module ifu_fetch_stage #(
    parameter logic [31:0] RESET_PC   = cpu_defs::RESET_PC,
    parameter logic [31:0] HANDLER_PC = cpu_defs::HANDLER_PC,
    parameter logic [31:0] IM_BASE    = cpu_defs::IM_BASE,
    parameter logic [31:0] IM_LAST    = cpu_defs::IM_LAST
) (
    input  logic               clk,
    input  logic               reset,
    ifu_fetch_stage_if.master  bus
);

    logic [31:0] pc;
    logic        adel;
    logic [31:0] fetched_instr;
    logic [4:0]  fetched_exc;

    // Bad targets are loaded as-is; AdEL only shows up once they are fetched
    assign adel          = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
    assign fetched_instr = adel ? cpu_defs::NOP : bus.i_inst_rdata;
    assign fetched_exc   = adel ? cpu_defs::EXC_ADEL : cpu_defs::EXC_NONE;

    assign bus.i_inst_addr = pc;
    assign bus.F_pc        = pc;

    // Next PC: exception redirect beats stall, stall beats jump, else sequential
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (bus.req) begin
            pc <= HANDLER_PC;
        end else if (bus.stall) begin
            pc <= pc;
        end else if (bus.jump_flag) begin
            pc <= bus.jump_target;
        end else begin
            pc <= pc + 32'd4;
        end
    end

    fd_pipe_reg #(
        .RESET_PC   (RESET_PC),
        .HANDLER_PC (HANDLER_PC)
    ) u_fd (
        .clk     (clk),
        .reset   (reset),
        .flush   (bus.req),
        .stall   (bus.stall),
        .kill    (bus.d_is_eret),
        .f_instr (fetched_instr),
        .f_pc    (pc),
        .f_exc   (fetched_exc),
        .f_bd    (bus.d_is_jump),
        .d_instr (bus.D_instr),
        .d_pc    (bus.D_pc),
        .d_exc   (bus.D_exc),
        .d_bd    (bus.D_bd)
    );

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// tb/tb_ifu_fetch_stage.sv - self-checking bench for ifu_fetch_stage
module tb_ifu_fetch_stage;

    localparam logic [31:0] P_RESET   = 32'h0000_3000;
    localparam logic [31:0] P_HANDLER = 32'h0000_4180;
    localparam logic [31:0] P_BASE    = 32'h0000_3000;
    localparam logic [31:0] P_LAST    = 32'h0000_6FFC;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    logic        use_fixed = 1'b0;
    logic [31:0] fixed_word = 32'h0;

    logic [31:0] m_pc, m_instr, m_dpc;
    logic [4:0]  m_exc;
    logic        m_bd;

    ifu_fetch_stage_if bus ();

    ifu_fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ a[15:0]};
    endfunction

    assign bus.i_inst_rdata = use_fixed ? fixed_word : mem_word(bus.i_inst_addr);

    function automatic logic [31:0] model_word(input logic [31:0] a);
        return use_fixed ? fixed_word : mem_word(a);
    endfunction

    task automatic model_reset();
        m_pc = P_RESET; m_instr = 32'h0; m_dpc = P_RESET; m_exc = 5'd0; m_bd = 1'b0;
    endtask

    task automatic model_step();
        bit bad;
        bad = (m_pc % 4 != 0) || (m_pc < P_BASE) || (m_pc > P_LAST);
        if (bus.req) begin
            m_pc = P_HANDLER;
            m_instr = 32'h0; m_dpc = P_HANDLER; m_exc = 5'd0; m_bd = 1'b0;
        end else if (!bus.stall) begin
            if (bus.d_is_eret) begin
                m_instr = 32'h0; m_exc = 5'd0; m_bd = 1'b0;
            end else begin
                m_instr = bad ? 32'h0 : model_word(m_pc);
                m_exc   = bad ? 5'd4 : 5'd0;
                m_bd    = bus.d_is_jump;
            end
            m_dpc = m_pc;
            m_pc  = bus.jump_flag ? bus.jump_target : m_pc + 32'd4;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall = 0; bus.req = 0; bus.jump_flag = 0; bus.jump_target = 32'h0;
        bus.d_is_jump = 0; bus.d_is_eret = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        n_tests++;
        if (bus.F_pc !== 32'h3000 || bus.D_pc !== 32'h3000 || bus.D_instr !== 32'h0 ||
            bus.D_exc !== 5'd0 || bus.D_bd !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: F_pc=%h D_pc=%h D_instr=%h D_exc=%0d D_bd=%b expected 3000/3000/0/0/0",
                     bus.F_pc, bus.D_pc, bus.D_instr, bus.D_exc, bus.D_bd);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        use_fixed = 1'b1; fixed_word = 32'h2408_0001;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_tests++;
            if (bus.F_pc !== 32'h3000 + 32'(4 * k) || bus.D_pc !== 32'h3000 + 32'(4 * (k - 1)) ||
                bus.D_instr !== 32'h2408_0001 || bus.D_exc !== 5'd0) begin
                n_fail++;
                $display("FAIL seq%0d: F_pc=%h D_pc=%h D_instr=%h D_exc=%0d expected %h/%h/24080001/0", k,
                         bus.F_pc, bus.D_pc, bus.D_instr, bus.D_exc,
                         32'h3000 + 32'(4 * k), 32'h3000 + 32'(4 * (k - 1)));
            end
        end
        use_fixed = 1'b0;
    endtask

    task automatic test_jump();
        tick();
        n_tests++;
        if (bus.F_pc !== 32'h3010) begin
            n_fail++; $display("FAIL jump_pre: F_pc=%h expected 3010", bus.F_pc);
        end
        bus.d_is_jump = 1; bus.jump_flag = 1; bus.jump_target = 32'h3100;
        tick();
        n_tests++;
        if (bus.F_pc !== 32'h3100 || bus.D_pc !== 32'h3010 || bus.D_bd !== 1'b1 ||
            bus.D_instr !== mem_word(32'h3010)) begin
            n_fail++;
            $display("FAIL jump: F_pc=%h D_pc=%h D_bd=%b D_instr=%h expected 3100/3010/1/%h",
                     bus.F_pc, bus.D_pc, bus.D_bd, bus.D_instr, mem_word(32'h3010));
        end
        clear_inputs();
        tick();
        n_tests++;
        if (bus.D_bd !== 1'b0 || bus.D_pc !== 32'h3100 || bus.F_pc !== 32'h3104) begin
            n_fail++;
            $display("FAIL jump_after: D_bd=%b D_pc=%h F_pc=%h expected 0/3100/3104",
                     bus.D_bd, bus.D_pc, bus.F_pc);
        end
    endtask

    task automatic test_stall();
        bus.jump_flag = 1; bus.jump_target = 32'h3020;
        tick();
        bus.stall = 1; bus.jump_flag = 1; bus.jump_target = 32'h3300;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_tests++;
            if (bus.F_pc !== 32'h3020 || bus.D_pc !== m_dpc || bus.D_instr !== m_instr ||
                bus.D_exc !== m_exc || bus.D_bd !== m_bd) begin
                n_fail++;
                $display("FAIL stall%0d: F_pc=%h D_pc=%h D_instr=%h expected 3020/%h/%h",
                         k, bus.F_pc, bus.D_pc, bus.D_instr, m_dpc, m_instr);
            end
        end
        clear_inputs();
        tick();
        n_tests++;
        if (bus.F_pc !== 32'h3024 || bus.D_pc !== 32'h3020) begin
            n_fail++;
            $display("FAIL stall_release: F_pc=%h D_pc=%h expected 3024/3020", bus.F_pc, bus.D_pc);
        end
    endtask

    task automatic test_req();
        bus.jump_flag = 1; bus.jump_target = 32'h3040;
        tick();
        clear_inputs();
        bus.stall = 1; bus.req = 1; bus.d_is_eret = 1;
        tick();
        n_tests++;
        if (bus.F_pc !== 32'h4180 || bus.D_instr !== 32'h0 || bus.D_pc !== 32'h4180 ||
            bus.D_exc !== 5'd0 || bus.D_bd !== 1'b0) begin
            n_fail++;
            $display("FAIL req: F_pc=%h D_instr=%h D_pc=%h D_exc=%0d D_bd=%b expected 4180/0/4180/0/0",
                     bus.F_pc, bus.D_instr, bus.D_pc, bus.D_exc, bus.D_bd);
        end
        clear_inputs();
        tick();
        n_tests++;
        if (bus.F_pc !== 32'h4184 || bus.D_pc !== 32'h4180 || bus.D_instr !== mem_word(32'h4180)) begin
            n_fail++;
            $display("FAIL req_fetch: F_pc=%h D_pc=%h D_instr=%h expected 4184/4180/%h",
                     bus.F_pc, bus.D_pc, bus.D_instr, mem_word(32'h4180));
        end
        tick();
        n_tests++;
        if (bus.F_pc !== 32'h4188 || bus.D_pc !== 32'h4184) begin
            n_fail++;
            $display("FAIL req_next: F_pc=%h D_pc=%h expected 4188/4184", bus.F_pc, bus.D_pc);
        end
    endtask

    task automatic test_adel();
        logic [31:0] tgt [4];
        logic [4:0]  exc [4];
        tgt[0] = 32'h3002; exc[0] = 5'd4;
        tgt[1] = 32'h7000; exc[1] = 5'd4;
        tgt[2] = 32'h6FFC; exc[2] = 5'd0;
        tgt[3] = 32'h2FFC; exc[3] = 5'd4;
        for (int k = 0; k < 4; k++) begin
            bus.jump_flag = 1; bus.jump_target = tgt[k];
            tick();
            clear_inputs();
            n_tests++;
            if (bus.F_pc !== tgt[k]) begin
                n_fail++; $display("FAIL adel_load%0d: F_pc=%h expected %h", k, bus.F_pc, tgt[k]);
            end
            tick();
            n_tests++;
            if (bus.D_exc !== exc[k] || bus.D_pc !== tgt[k] || bus.F_pc !== tgt[k] + 32'd4 ||
                bus.D_instr !== ((exc[k] != 0) ? 32'h0 : mem_word(tgt[k]))) begin
                n_fail++;
                $display("FAIL adel%0d: D_exc=%0d D_pc=%h F_pc=%h D_instr=%h expected %0d/%h/%h",
                         k, bus.D_exc, bus.D_pc, bus.F_pc, bus.D_instr, exc[k], tgt[k], tgt[k] + 32'd4);
            end
        end
    endtask

    task automatic test_eret_reset();
        bus.jump_flag = 1; bus.jump_target = 32'h3080;
        tick();
        bus.d_is_eret = 1; bus.d_is_jump = 1; bus.jump_flag = 1; bus.jump_target = 32'h3200;
        tick();
        clear_inputs();
        n_tests++;
        if (bus.F_pc !== 32'h3200 || bus.D_instr !== 32'h0 || bus.D_bd !== 1'b0 ||
            bus.D_pc !== 32'h3080 || bus.D_exc !== 5'd0) begin
            n_fail++;
            $display("FAIL eret: F_pc=%h D_instr=%h D_bd=%b D_pc=%h expected 3200/0/0/3080",
                     bus.F_pc, bus.D_instr, bus.D_bd, bus.D_pc);
        end
        tick();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if (bus.F_pc !== 32'h3000 || bus.D_pc !== 32'h3000 || bus.D_instr !== 32'h0 ||
            bus.D_exc !== 5'd0 || bus.D_bd !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: F_pc=%h D_pc=%h D_instr=%h D_exc=%0d D_bd=%b expected 3000/3000/0/0/0",
                     bus.F_pc, bus.D_pc, bus.D_instr, bus.D_exc, bus.D_bd);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            bus.req       = ($urandom_range(0, 15) == 0);
            bus.stall     = ($urandom_range(0, 3) == 0);
            bus.jump_flag = ($urandom_range(0, 3) == 0);
            bus.d_is_eret = ($urandom_range(0, 7) == 0);
            bus.d_is_jump = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0, 1: bus.jump_target = P_BASE + 32'($urandom_range(0, 4095)) * 32'd4;
                2:    bus.jump_target = P_BASE + 32'($urandom_range(0, 4095)) * 32'd4 + 32'($urandom_range(1, 3));
                default: bus.jump_target = $urandom;
            endcase
            tick();
            n_tests++;
            if (bus.F_pc !== m_pc || bus.i_inst_addr !== m_pc || bus.D_instr !== m_instr ||
                bus.D_pc !== m_dpc || bus.D_exc !== m_exc || bus.D_bd !== m_bd) begin
                n_fail++;
                $display("FAIL rand%0d: got pc=%h addr=%h instr=%h dpc=%h exc=%0d bd=%b expected pc=%h instr=%h dpc=%h exc=%0d bd=%b",
                         k, bus.F_pc, bus.i_inst_addr, bus.D_instr, bus.D_pc, bus.D_exc, bus.D_bd,
                         m_pc, m_instr, m_dpc, m_exc, m_bd);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_sequential();
        test_jump();
        test_stall();
        test_req();
        test_adel();
        test_eret_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
